// File: rtl/types_pkg.sv
// Shared geometry types for the render pipeline, plus the model streamer's
// FSM state encoding and output-FIFO entry layout.
package types_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } streamer_state_t;

    typedef struct packed {
        triangle_t data;
        logic      last;
    } fifo_entry_t;

endpackage

// File: rtl/model_streamer_triangle_fifo.sv
// Synchronous FIFO of {triangle, last}; the head is forced to zero while empty
// so the downstream bus shows clean values after reset.
module triangle_fifo
    import types_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  triangle_t        push_triangle,
    input  logic             push_last,
    input  logic             pop,
    output triangle_t        head_triangle,
    output logic             head_last,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count == CNT_W'(0));
    assign do_push_s = push && (count != CNT_W'(DEPTH));
    assign do_pop_s  = pop && !empty;

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= '{data: push_triangle, last: push_last};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count    <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation, zeroed while empty.
    always_comb begin
        if (empty) begin
            head_triangle = '0;
            head_last     = 1'b0;
        end else begin
            head_triangle = mem[rd_ptr_r].data;
            head_last     = mem[rd_ptr_r].last;
        end
    end

endmodule

// File: rtl/model_streamer.sv
// Walks the model triangle ROM and streams triangles through a small FIFO.
// Build option MODEL_STREAMER_LOOP_EN: holding start replays the model back to back.
module model_streamer
    import types_pkg::*;
#(
    parameter int TRIANGLE_COUNT = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(TRIANGLE_COUNT),
    localparam int CW = $clog2(TRIANGLE_COUNT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] triangle_count,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_address,
    input  triangle_t     rom_triangle,
    output triangle_t     triangle,
    output logic          triangle_valid,
    input  logic          triangle_ready,
    output logic          triangle_last
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OW  = FCW + 1;

    streamer_state_t state_r;
    logic            busy_r;
    logic            done_r;
    logic            pend_r;
    logic            pend_last_r;
    logic [CW-1:0]   next_index_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   clamped_count_s;
    logic [OW-1:0]   occupancy_s;
    logic            issue_s;
    logic            last_issue_s;
    logic            pop_s;
    logic            fifo_empty_s;
    logic [FCW-1:0]  fifo_count_s;

    triangle_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (pend_r),
        .push_triangle (rom_triangle),
        .push_last     (pend_last_r),
        .pop           (pop_s),
        .head_triangle (triangle),
        .head_last     (triangle_last),
        .empty         (fifo_empty_s),
        .count         (fifo_count_s)
    );

    assign triangle_valid = !fifo_empty_s;
    assign pop_s          = triangle_valid && triangle_ready;
    assign rom_address    = next_index_r[AW-1:0];
    assign busy           = busy_r;
    assign done           = done_r;

    // Requested count limited to the ROM depth.
    always_comb begin
        if (triangle_count > CW'(TRIANGLE_COUNT)) begin
            clamped_count_s = CW'(TRIANGLE_COUNT);
        end else begin
            clamped_count_s = triangle_count;
        end
    end

    // Issue only when the FIFO can take this read plus the one in flight, ignoring pops.
    always_comb begin
        occupancy_s  = OW'(fifo_count_s) + OW'(pend_r) + OW'(1);
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        if ((state_r == ST_FETCH) && (occupancy_s <= OW'(FIFO_DEPTH))) begin
            issue_s      = 1'b1;
            last_issue_s = (next_index_r == (count_r - CW'(1)));
        end else begin
            issue_s      = 1'b0;
            last_issue_s = 1'b0;
        end
    end

    // Sequencer FSM, read-pending pipeline and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pend_r       <= 1'b0;
            pend_last_r  <= 1'b0;
            next_index_r <= CW'(0);
            count_r      <= CW'(0);
        end else begin
            pend_r      <= issue_s;
            pend_last_r <= last_issue_s;
            done_r      <= pop_s && triangle_last;
            case (state_r)
                ST_IDLE: begin
                    if (start && (clamped_count_s != CW'(0))) begin
                        state_r      <= ST_FETCH;
                        busy_r       <= 1'b1;
                        next_index_r <= CW'(0);
                        count_r      <= clamped_count_s;
                    end else if (start) begin
                        done_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (last_issue_s) begin
`ifdef MODEL_STREAMER_LOOP_EN
                        if (start) begin
                            next_index_r <= CW'(0);
                        end else begin
                            next_index_r <= next_index_r + CW'(1);
                            state_r      <= ST_DRAIN;
                        end
`else
                        next_index_r <= next_index_r + CW'(1);
                        state_r      <= ST_DRAIN;
`endif
                    end else if (issue_s) begin
                        next_index_r <= next_index_r + CW'(1);
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the final pop so done lands exactly one cycle later.
                    if (!pend_r && pop_s && (fifo_count_s == FCW'(1))) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (!pend_r && fifo_empty_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_model_streamer.sv
// Scoreboard bench for model_streamer: randomized ROM contents and ready,
// expected stream derived from the run count and a behavioural ROM model.
module tb_model_streamer;
    import types_pkg::*;

    localparam int TC = 6;
    localparam int FD = 4;
    localparam int AW = $clog2(TC);
    localparam int CW = $clog2(TC + 1);
    localparam int TW = $bits(triangle_t);
    localparam int EW = TW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] triangle_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_address;
    triangle_t     rom_triangle;
    triangle_t     triangle;
    logic          triangle_valid;
    logic          triangle_ready;
    logic          triangle_last;

    triangle_t         rom_mem [1 << AW];
    logic [EW-1:0]     exp_q [$];
    int                pop_cycles [$];
    int                checks = 0;
    int                errors = 0;
    int                pop_count = 0;
    int                passes_left = 0;
    int                max_fifo = 0;
    int                cyc = 0;
    bit                model_busy = 1'b0;
    bit                clear_busy = 1'b0;
    bit                done_next = 1'b0;
    bit                rand_ready_en = 1'b0;

    model_streamer #(.TRIANGLE_COUNT(TC), .FIFO_DEPTH(FD)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .triangle_count (triangle_count),
        .busy           (busy),
        .done           (done),
        .rom_address    (rom_address),
        .rom_triangle   (rom_triangle),
        .triangle       (triangle),
        .triangle_valid (triangle_valid),
        .triangle_ready (triangle_ready),
        .triangle_last  (triangle_last)
    );

    always #5 clk = ~clk;

    // Registered-output ROM with one cycle of read latency.
    always @(posedge clk) begin
        rom_triangle <= rom_mem[rom_address];
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            triangle_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: busy/done model plus in-order comparison of every handshake.
    always @(negedge clk) begin
        logic [EW-1:0] exp;
        if (!reset) begin
            if (clear_busy) begin
                model_busy = 1'b0;
                clear_busy = 1'b0;
            end
            chk("busy", EW'(busy), EW'(model_busy));
            chk("done", EW'(done), EW'(done_next));
            done_next = 1'b0;
            if (int'(u_dut.u_fifo.count) > max_fifo) max_fifo = int'(u_dut.u_fifo.count);
            if (triangle_valid && exp_q.size() == 0) begin
                chk("unexpected valid", EW'(triangle_valid), EW'(0));
            end else if (triangle_valid && triangle_ready) begin
                exp = exp_q.pop_front();
                chk("pop data", {triangle, triangle_last}, exp);
                pop_count++;
                pop_cycles.push_back(cyc);
                if (exp[0]) begin
                    done_next = 1'b1;
                    passes_left--;
                    if (passes_left == 0) clear_busy = 1'b1;
                end
            end
        end
    end

    task automatic load_expect(input int cnt, input int passes);
        int n;
        n = (cnt > TC) ? TC : cnt;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({rom_mem[i], (i == n - 1) ? 1'b1 : 1'b0});
            end
        end
    endtask

    // Pulse start for one edge; leaves the caller in cycle 1 of the run.
    task automatic start_run(input int cnt);
        int n;
        n = (cnt > TC) ? TC : cnt;
        load_expect(cnt, 1);
        triangle_count = CW'(cnt);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (n > 0) begin
            model_busy  = 1'b1;
            passes_left = 1;
        end else begin
            done_next = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !model_busy && !done_next && !clear_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, EW'(ok), EW'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " busy"}, EW'(busy), EW'(0));
        chk({name, " done"}, EW'(done), EW'(0));
        chk({name, " valid"}, EW'(triangle_valid), EW'(0));
        chk({name, " last"}, EW'(triangle_last), EW'(0));
        chk({name, " triangle"}, EW'(triangle), EW'(0));
        chk({name, " rom_address"}, EW'(rom_address), EW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [159:0] tmp;
        int           base;
        for (int i = 0; i < (1 << AW); i++) begin
            tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rom_mem[i] = (i < TC) ? triangle_t'(tmp[TW-1:0]) : triangle_t'(0);
        end
        reset = 1'b1;
        start = 1'b0;
        triangle_count = '0;
        triangle_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic run with first-valid latency.
        triangle_ready = 1'b1;
        start_run(3);
        @(negedge clk);
        chk("latency c1 valid", EW'(triangle_valid), EW'(0));
        @(negedge clk);
        chk("latency c2 valid", EW'(triangle_valid), EW'(0));
        @(negedge clk);
        chk("latency c3 valid", EW'(triangle_valid), EW'(1));
        wait_idle("basic complete");

        // Backpressure: ready low for 10 cycles.
        triangle_ready = 1'b0;
        max_fifo = 0;
        start_run(TC);
        repeat (10) @(posedge clk);
        #1;
        triangle_ready = 1'b1;
        wait_idle("backpressure complete");
        chk("fifo saturation", EW'(max_fifo), EW'(FD));

        // Zero count.
        start_run(0);
        repeat (4) @(posedge clk);
        #1;
        wait_idle("zero complete");

        // Clamp and start while busy.
        start_run(7);
        @(posedge clk);
        #1;
        triangle_count = CW'(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("clamp complete");

        // Reset mid-run after the second pop.
        base = pop_count;
        start_run(5);
        for (int k = 0; k < 100 && pop_count < base + 2; k++) @(negedge clk);
        chk("second pop seen", EW'(pop_count >= base + 2), EW'(1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun reset");
        exp_q.delete();
        model_busy = 1'b0;
        clear_busy = 1'b0;
        done_next = 1'b0;
        passes_left = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start_run(3);
        wait_idle("replay complete");

        // Randomized runs with random ready.
        rand_ready_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            start_run($urandom_range(0, 7));
            wait_idle("random run complete");
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2;
        triangle_ready = 1'b1;

`ifdef MODEL_STREAMER_LOOP_EN
        // Start held across two passes; no bubble at the wrap.
        pop_cycles.delete();
        load_expect(3, 2);
        triangle_count = CW'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        model_busy = 1'b1;
        passes_left = 2;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("loop complete");
        chk("loop pop count", EW'(pop_cycles.size()), EW'(6));
        if (pop_cycles.size() == 6) begin
            chk("loop no bubble", EW'(pop_cycles[5] - pop_cycles[0]), EW'(5));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
